// File: rtl/timer_pkg.sv
// Shared types, encodings and limits for the countdown sequencer.
package timer_pkg;

  localparam int unsigned DEFAULT_TICKS_PER_SEC = 50000000;
  localparam int unsigned DEFAULT_FLASH_TICKS   = 25000000;

  localparam logic [3:0] TEN_SEC_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;

  typedef enum logic [2:0] {
    ST_SET_SEC = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // MM:SS as four BCD digits, most significant first
  typedef struct packed {
    logic [3:0] ten_min;
    logic [3:0] one_min;
    logic [3:0] ten_sec;
    logic [3:0] one_sec;
  } bcd_time_t;

  // Saturate a raw switch nibble to the largest legal digit value
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-second tick; holds when en is low.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned TICKS = DEFAULT_TICKS_PER_SEC
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] r_cnt;

  // Terminal-count decode; the owner qualifies it with its run state
  assign tick = (r_cnt == LAST);

  // Cycle counter 0..TICKS-1, wrapping at terminal count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// MM:SS countdown timer: set seconds/minutes, run/pause, flash LEDs when done.
module countdown_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int unsigned FLASH_TICKS   = DEFAULT_FLASH_TICKS
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] set_val,
  input  logic       next_pulse,
  input  logic       run_pulse,
  output logic [3:0] ten_min,
  output logic [3:0] one_min,
  output logic [3:0] ten_sec,
  output logic [3:0] one_sec,
  output logic [2:0] state_o,
  output logic [9:0] ledr
);

  localparam int unsigned FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);
  localparam bcd_time_t LAST_SECOND = '{ten_min: 4'd0, one_min: 4'd0, ten_sec: 4'd0, one_sec: 4'd1};

  state_e          r_state;
  bcd_time_t       r_time;
  logic            r_led;
  logic [FW-1:0]   r_flash;

  state_e          w_state_nxt;
  bcd_time_t       w_time_nxt;
  bcd_time_t       w_time_dec;
  logic            w_led_nxt;
  logic [FW-1:0]   w_flash_nxt;
  logic            w_pre_clr;
  logic            w_pre_en;
  logic            w_pre_tick;

  tick_prescaler #(
    .TICKS (TICKS_PER_SEC)
  ) u_prescaler (
    .clock (CLOCK_50),
    .reset (reset),
    .clr   (w_pre_clr),
    .en    (w_pre_en),
    .tick  (w_pre_tick)
  );

  // BCD decrement with borrow; only used while running, where the value is never 00:00
  always_comb begin
    w_time_dec = r_time;
    if (r_time.one_sec != 4'd0) begin
      w_time_dec.one_sec = r_time.one_sec - 4'd1;
    end else begin
      w_time_dec.one_sec = DIGIT_MAX;
      if (r_time.ten_sec != 4'd0) begin
        w_time_dec.ten_sec = r_time.ten_sec - 4'd1;
      end else begin
        w_time_dec.ten_sec = TEN_SEC_MAX;
        if (r_time.one_min != 4'd0) begin
          w_time_dec.one_min = r_time.one_min - 4'd1;
        end else begin
          w_time_dec.one_min = DIGIT_MAX;
          w_time_dec.ten_min = r_time.ten_min - 4'd1;
        end
      end
    end
  end

  // Next-state, digit, LED and prescaler control
  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_led_nxt   = r_led;
    w_flash_nxt = r_flash;
    w_pre_clr   = 1'b0;
    w_pre_en    = 1'b0;

    case (r_state)
      ST_SET_SEC, ST_SET_MIN: begin
        if (run_pulse) begin
          if (r_time == '0) begin
            w_state_nxt = ST_DONE;
            w_led_nxt   = 1'b1;
            w_flash_nxt = '0;
          end else begin
            w_state_nxt = ST_RUN;
            w_pre_clr   = 1'b1;
          end
        end else if (next_pulse) begin
          // From minutes, next wraps back so seconds can be re-edited
          w_state_nxt = (r_state == ST_SET_SEC) ? ST_SET_MIN : ST_SET_SEC;
        end else if (r_state == ST_SET_SEC) begin
          w_time_nxt.ten_sec = bcd_clamp(set_val[7:4], TEN_SEC_MAX);
          w_time_nxt.one_sec = bcd_clamp(set_val[3:0], DIGIT_MAX);
        end else begin
          w_time_nxt.ten_min = bcd_clamp(set_val[7:4], DIGIT_MAX);
          w_time_nxt.one_min = bcd_clamp(set_val[3:0], DIGIT_MAX);
        end
      end

      ST_RUN: begin
        // A tick coincident with pause still wraps the prescaler so the second is not counted twice
        w_pre_en = !run_pulse || w_pre_tick;
        if (w_pre_tick) begin
          w_time_nxt = w_time_dec;
          if (r_time == LAST_SECOND) begin
            w_state_nxt = ST_DONE;
            w_led_nxt   = 1'b1;
            w_flash_nxt = '0;
          end else if (run_pulse) begin
            w_state_nxt = ST_PAUSE;
          end
        end else if (run_pulse) begin
          w_state_nxt = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (run_pulse) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_DONE: begin
        if (next_pulse) begin
          w_state_nxt = ST_SET_SEC;
          w_led_nxt   = 1'b0;
          w_flash_nxt = '0;
        end else if (r_flash == FLASH_LAST) begin
          w_flash_nxt = '0;
          w_led_nxt   = !r_led;
        end else begin
          w_flash_nxt = r_flash + FW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_SET_SEC;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_SET_SEC;
      r_time  <= '0;
      r_led   <= 1'b0;
      r_flash <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_led   <= w_led_nxt;
      r_flash <= w_flash_nxt;
    end
  end

  assign ten_min = r_time.ten_min;
  assign one_min = r_time.one_min;
  assign ten_sec = r_time.ten_sec;
  assign one_sec = r_time.one_sec;
  assign state_o = r_state;
  assign ledr    = {10{r_led}};

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer against a seconds-based reference model.
module tb_countdown_sequencer;

  localparam int T = 4;
  localparam int F = 2;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] set_val;
  logic       next_pulse;
  logic       run_pulse;
  logic [3:0] ten_min, one_min, ten_sec, one_sec;
  logic [2:0] state_o;
  logic [9:0] ledr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode number, minutes, seconds, cycles into the current second, cycles spent done
  int m_st, m_min, m_sec, m_phase, m_done_cyc;

  countdown_sequencer #(
    .TICKS_PER_SEC (T),
    .FLASH_TICKS   (F)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .set_val    (set_val),
    .next_pulse (next_pulse),
    .run_pulse  (run_pulse),
    .ten_min    (ten_min),
    .one_min    (one_min),
    .ten_sec    (ten_sec),
    .one_sec    (one_sec),
    .state_o    (state_o),
    .ledr       (ledr)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_min = 0; m_sec = 0; m_phase = 0; m_done_cyc = 0;
  endtask

  task automatic enter_done();
    m_st = 4; m_done_cyc = 0;
  endtask

  // Advance the model by one clock edge given the inputs seen before it
  task automatic model_edge(input logic nx, input logic rn, input logic [7:0] sv);
    int total;
    case (m_st)
      0, 1: begin
        if (rn) begin
          if (m_min == 0 && m_sec == 0) enter_done();
          else begin m_st = 2; m_phase = 0; end
        end else if (nx) begin
          m_st = (m_st == 0) ? 1 : 0;
        end else if (m_st == 0) begin
          m_sec = imin(int'(sv[7:4]), 5) * 10 + imin(int'(sv[3:0]), 9);
        end else begin
          m_min = imin(int'(sv[7:4]), 9) * 10 + imin(int'(sv[3:0]), 9);
        end
      end
      2: begin
        if (m_phase == T - 1) begin
          m_phase = 0;
          total = m_min * 60 + m_sec - 1;
          m_min = total / 60;
          m_sec = total % 60;
          if (total == 0) enter_done();
          else if (rn) m_st = 3;
        end else if (rn) begin
          m_st = 3;
        end else begin
          m_phase++;
        end
      end
      3: if (rn) m_st = 2;
      4: begin
        if (nx) m_st = 0;
        else m_done_cyc++;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic m_led;
    m_led = (m_st == 4) && (((m_done_cyc / F) % 2) == 0);
    check({tag, "_ten_min"}, 16'(ten_min), 16'(m_min / 10));
    check({tag, "_one_min"}, 16'(one_min), 16'(m_min % 10));
    check({tag, "_ten_sec"}, 16'(ten_sec), 16'(m_sec / 10));
    check({tag, "_one_sec"}, 16'(one_sec), 16'(m_sec % 10));
    check({tag, "_state"},   16'(state_o), 16'(m_st));
    check({tag, "_ledr"},    16'(ledr),    m_led ? 16'h03FF : 16'h0000);
  endtask

  // One clock with the given inputs, then compare against the model
  task automatic step(input logic nx, input logic rn, input logic [7:0] sv);
    next_pulse = nx; run_pulse = rn; set_val = sv;
    @(posedge CLOCK_50);
    model_edge(nx, rn, sv);
    #1;
    next_pulse = 1'b0; run_pulse = 1'b0;
    check_all("step");
  endtask

  // Reset asserted between edges must clear everything without a clock
  task automatic async_reset(input string tag);
    @(negedge CLOCK_50);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_ten_min"}, 16'(ten_min), 16'd0);
    check({tag, "_one_min"}, 16'(one_min), 16'd0);
    check({tag, "_ten_sec"}, 16'(ten_sec), 16'd0);
    check({tag, "_one_sec"}, 16'(one_sec), 16'd0);
    check({tag, "_state"},   16'(state_o), 16'd0);
    check({tag, "_ledr"},    16'(ledr),    16'd0);
    model_reset();
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; set_val = 8'h00; next_pulse = 1'b0; run_pulse = 1'b0;
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    check_all("por");
    reset = 1'b0;

    // First load lands on the first edge after reset release
    step(1'b0, 1'b0, 8'h34);
    check("load_first_ten_sec", 16'(ten_sec), 16'd3);
    check("load_first_one_sec", 16'(one_sec), 16'd4);

    // Clamping of seconds then minutes
    step(1'b0, 1'b0, 8'hF7);
    check("clamp_ten_sec", 16'(ten_sec), 16'd5);
    check("clamp_one_sec", 16'(one_sec), 16'd7);
    step(1'b1, 1'b0, 8'hFF);
    check("next_state", 16'(state_o), 16'd1);
    check("next_skip_load", 16'(one_sec), 16'd7);
    step(1'b0, 1'b0, 8'h12);
    check("min_ten_min", 16'(ten_min), 16'd1);
    check("min_one_min", 16'(one_min), 16'd2);
    check("min_hold_sec", 16'(ten_sec), 16'd5);
    step(1'b0, 1'b0, 8'hAF);
    check("min_clamp_ten", 16'(ten_min), 16'd9);
    check("min_clamp_one", 16'(one_min), 16'd9);

    // 01:00 counts down with borrow across minutes
    async_reset("rst_a");
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    check("pre_tick_one_min", 16'(one_min), 16'd1);
    step(1'b0, 1'b0, 8'h00);
    check("borrow_59", 16'({ten_min, one_min, ten_sec, one_sec}), 16'h0059);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check("borrow_58", 16'({ten_min, one_min, ten_sec, one_sec}), 16'h0058);

    // Reset in the middle of running 03:27
    async_reset("rst_b");
    step(1'b0, 1'b0, 8'h27);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h03);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("run_0327_state", 16'(state_o), 16'd2);
    async_reset("rst_mid_run");

    // 00:01 expires into DONE and flashes
    step(1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b1, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check("done_digits", 16'({ten_min, one_min, ten_sec, one_sec}), 16'h0000);
    check("done_state", 16'(state_o), 16'd4);
    check("done_led_on0", 16'(ledr), 16'h03FF);
    step(1'b0, 1'b1, 8'h00);
    check("done_led_on1", 16'(ledr), 16'h03FF);
    check("done_ignores_run", 16'(state_o), 16'd4);
    step(1'b0, 1'b0, 8'h00);
    check("done_led_off", 16'(ledr), 16'h0000);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("done_exit_state", 16'(state_o), 16'd0);
    check("done_exit_led", 16'(ledr), 16'h0000);

    // Pause with prescaler at 2, hold, resume ticks two cycles later
    async_reset("rst_c");
    step(1'b0, 1'b0, 8'h30);
    step(1'b0, 1'b1, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("pause_state", 16'(state_o), 16'd3);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h99);
    check("pause_hold", 16'({ten_min, one_min, ten_sec, one_sec}), 16'h0030);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("resume_no_tick", 16'(one_sec), 16'd0);
    step(1'b0, 1'b0, 8'h00);
    check("resume_tick", 16'({ten_sec, one_sec}), 16'h0029);

    // All-zero start goes straight to DONE; then reset while flashing
    async_reset("rst_d");
    step(1'b0, 1'b1, 8'h00);
    check("zero_start_done", 16'(state_o), 16'd4);
    step(1'b0, 1'b0, 8'h00);
    async_reset("rst_mid_done");

    // run beats next when both pulse together
    step(1'b0, 1'b0, 8'h05);
    step(1'b1, 1'b1, 8'h00);
    check("run_priority", 16'(state_o), 16'd2);

    // Randomized traffic, small set values favoured so DONE is reachable
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] sv;
      sv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 23) == 0), sv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
